// File: rtl/mem_lsu.sv
// Load/store unit between EX/MEM and MEM/WB: runs one data-bus transaction per memory op
// and stalls upstream until the bus acknowledges. Misaligned accesses raise an exception instead.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_pc,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_store_data,
    output logic        stall_req,
    output logic        mem_valid,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_pc,
    output logic [7:0]  mem_aluop,
    output logic        misalign_exc,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 8;

    localparam logic [OP_W-1:0] OP_LB  = 8'h20;
    localparam logic [OP_W-1:0] OP_LH  = 8'h21;
    localparam logic [OP_W-1:0] OP_LW  = 8'h23;
    localparam logic [OP_W-1:0] OP_LBU = 8'h24;
    localparam logic [OP_W-1:0] OP_LHU = 8'h25;
    localparam logic [OP_W-1:0] OP_SB  = 8'h28;
    localparam logic [OP_W-1:0] OP_SH  = 8'h29;
    localparam logic [OP_W-1:0] OP_SW  = 8'h2B;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q;
    logic              mem_valid_q, mem_wreg_q, misalign_q;
    logic [REG_W-1:0]  mem_wd_q, lat_wd_q;
    logic [XLEN-1:0]   mem_wdata_q, mem_pc_q, lat_pc_q;
    logic [OP_W-1:0]   mem_aluop_q, lat_aluop_q;
    logic              lat_wreg_q;
    logic [1:0]        lat_off_q;
    logic              dbus_req_q, dbus_we_q;
    logic [3:0]        dbus_sel_q;
    logic [XLEN-1:0]   dbus_addr_q, dbus_wdata_q;

    logic              is_load_c, is_store_c, is_mem_c, aligned_c;
    logic [3:0]        sel_c;
    logic [XLEN-1:0]   st_data_c, load_data_c;
    logic [7:0]        lane_b_c;
    logic [15:0]       lane_h_c;

    // Decode the incoming op: class, alignment, byte lanes and replicated store data.
    always_comb begin
        is_load_c  = 1'b0;
        is_store_c = 1'b0;
        aligned_c  = 1'b1;
        sel_c      = 4'b1111;
        st_data_c  = ex_store_data;
        case (ex_aluop)
            OP_LB, OP_LBU, OP_SB: begin
                sel_c     = 4'b1000 >> ex_mem_addr[1:0];
                st_data_c = {4{ex_store_data[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                aligned_c = ~ex_mem_addr[0];
                sel_c     = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
                st_data_c = {2{ex_store_data[15:0]}};
            end
            OP_LW, OP_SW: aligned_c = (ex_mem_addr[1:0] == 2'b00);
            default: ;
        endcase
        case (ex_aluop)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load_c  = 1'b1;
            OP_SB, OP_SH, OP_SW:                 is_store_c = 1'b1;
            default: ;
        endcase
        is_mem_c = is_load_c | is_store_c;
    end

    // Extract the addressed big-endian lane from read data and extend it.
    always_comb begin
        lane_b_c    = 8'h00;
        lane_h_c    = lat_off_q[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];
        load_data_c = dbus_rdata;
        case (lat_off_q)
            2'd0:    lane_b_c = dbus_rdata[31:24];
            2'd1:    lane_b_c = dbus_rdata[23:16];
            2'd2:    lane_b_c = dbus_rdata[15:8];
            default: lane_b_c = dbus_rdata[7:0];
        endcase
        case (lat_aluop_q)
            OP_LB:   load_data_c = {{(XLEN-8){lane_b_c[7]}}, lane_b_c};
            OP_LBU:  load_data_c = {{(XLEN-8){1'b0}}, lane_b_c};
            OP_LH:   load_data_c = {{(XLEN-16){lane_h_c[15]}}, lane_h_c};
            OP_LHU:  load_data_c = {{(XLEN-16){1'b0}}, lane_h_c};
            default: load_data_c = dbus_rdata;
        endcase
    end

    assign stall_req = rst & (((state_q == IDLE) & ex_valid & is_mem_c & aligned_c) |
                              ((state_q == BUSY) & ~dbus_ack));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            mem_valid_q  <= 1'b0;
            mem_wd_q     <= '0;
            mem_wreg_q   <= 1'b0;
            mem_wdata_q  <= '0;
            mem_pc_q     <= '0;
            mem_aluop_q  <= '0;
            misalign_q   <= 1'b0;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_sel_q   <= '0;
            dbus_addr_q  <= '0;
            dbus_wdata_q <= '0;
            lat_wd_q     <= '0;
            lat_wreg_q   <= 1'b0;
            lat_pc_q     <= '0;
            lat_aluop_q  <= '0;
            lat_off_q    <= '0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    mem_valid_q <= 1'b0;
                    if (ex_valid) begin
                        mem_wd_q    <= ex_wd;
                        mem_pc_q    <= ex_pc;
                        mem_aluop_q <= ex_aluop;
                        if (!is_mem_c) begin
                            mem_valid_q <= 1'b1;
                            mem_wreg_q  <= ex_wreg;
                            mem_wdata_q <= ex_wdata;
                        end else if (!aligned_c) begin
                            mem_valid_q <= 1'b1;
                            mem_wreg_q  <= 1'b0;
                            mem_wdata_q <= ex_mem_addr;
                            misalign_q  <= 1'b1;
                        end else begin
                            state_q      <= BUSY;
                            dbus_req_q   <= 1'b1;
                            dbus_we_q    <= is_store_c;
                            dbus_sel_q   <= sel_c;
                            dbus_addr_q  <= {ex_mem_addr[31:2], 2'b00};
                            dbus_wdata_q <= st_data_c;
                            lat_wd_q     <= ex_wd;
                            lat_wreg_q   <= ex_wreg;
                            lat_pc_q     <= ex_pc;
                            lat_aluop_q  <= ex_aluop;
                            lat_off_q    <= ex_mem_addr[1:0];
                        end
                    end
                end
                default: begin
                    mem_valid_q <= 1'b0;
                    if (dbus_ack) begin
                        state_q     <= IDLE;
                        dbus_req_q  <= 1'b0;
                        mem_valid_q <= 1'b1;
                        mem_wd_q    <= lat_wd_q;
                        mem_pc_q    <= lat_pc_q;
                        mem_aluop_q <= lat_aluop_q;
                        mem_wreg_q  <= dbus_we_q ? 1'b0 : lat_wreg_q;
                        mem_wdata_q <= dbus_we_q ? '0 : load_data_c;
                    end
                end
            endcase
        end
    end

    assign mem_valid    = mem_valid_q;
    assign mem_wd       = mem_wd_q;
    assign mem_wreg     = mem_wreg_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_pc       = mem_pc_q;
    assign mem_aluop    = mem_aluop_q;
    assign misalign_exc = misalign_q;
    assign dbus_req     = dbus_req_q;
    assign dbus_we      = dbus_we_q;
    assign dbus_sel     = dbus_sel_q;
    assign dbus_addr    = dbus_addr_q;
    assign dbus_wdata   = dbus_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: scenario tasks drive ops and push expected MEM/WB results;
// a monitor pops and compares each result as mem_valid appears.
module tb_mem_lsu;

    localparam logic [7:0] LB = 8'h20, LH = 8'h21, LW = 8'h23, LBU = 8'h24, LHU = 8'h25;
    localparam logic [7:0] SB = 8'h28, SH = 8'h29, SW = 8'h2B, ADD = 8'h10;

    logic        clk, rst, ex_valid, ex_wreg, stall_req, mem_valid, mem_wreg, misalign_exc;
    logic [4:0]  ex_wd, mem_wd;
    logic [31:0] ex_wdata, ex_pc, ex_mem_addr, ex_store_data, mem_wdata, mem_pc;
    logic [7:0]  ex_aluop, mem_aluop;
    logic        dbus_req, dbus_we, dbus_ack;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic        exc;
    } res_t;

    res_t exp_q[$];
    res_t mon_exp, mon_act;
    int   n_pass = 0;
    int   n_total = 0;

    mem_lsu dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
        .ex_wdata(ex_wdata), .ex_pc(ex_pc), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
        .ex_store_data(ex_store_data), .stall_req(stall_req), .mem_valid(mem_valid),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_pc(mem_pc),
        .mem_aluop(mem_aluop), .misalign_exc(misalign_exc), .dbus_req(dbus_req),
        .dbus_we(dbus_we), .dbus_sel(dbus_sel), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every mem_valid must match the oldest expected result.
    always @(posedge clk) begin
        #1;
        if (rst === 1'b1) begin
            n_total++;
            if (mem_valid === 1'b1) begin
                mon_act = {mem_wd, mem_wreg, mem_wdata, mem_pc, mem_aluop, misalign_exc};
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_result got pc=%h wdata=%h", mem_pc, mem_wdata);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp)
                        $display("FAIL result pc=%h got wd=%0d wreg=%b wdata=%h aluop=%h exc=%b required wd=%0d wreg=%b wdata=%h aluop=%h exc=%b",
                                 mon_exp.pc, mon_act.wd, mon_act.wreg, mon_act.wdata, mon_act.aluop, mon_act.exc,
                                 mon_exp.wd, mon_exp.wreg, mon_exp.wdata, mon_exp.aluop, mon_exp.exc);
                    else n_pass++;
                end
            end else begin
                if (misalign_exc !== 1'b0)
                    $display("FAIL exc_without_valid got %b required 0", misalign_exc);
                else n_pass++;
            end
        end
    end

    function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = (off == 2'd0) ? rd[31:24] : (off == 2'd1) ? rd[23:16] : (off == 2'd2) ? rd[15:8] : rd[7:0];
        h = (off == 2'd0) ? rd[31:16] : rd[15:0];
        case (op)
            LB:      return {{24{b[7]}}, b};
            LBU:     return {24'h0, b};
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [1:0] off);
        if (op == LB || op == LBU || op == SB)
            return (off == 2'd0) ? 4'b1000 : (off == 2'd1) ? 4'b0100 : (off == 2'd2) ? 4'b0010 : 4'b0001;
        if (op == LH || op == LHU || op == SH)
            return (off == 2'd0) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_sdata(input logic [7:0] op, input logic [31:0] d);
        if (op == SB) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (op == SH) return {d[15:0], d[15:0]};
        return d;
    endfunction

    task automatic drive_ex(input logic [7:0] op, input logic [4:0] wd, input logic [31:0] wdata,
                            input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] sdata);
        ex_valid = 1'b1; ex_aluop = op; ex_wd = wd; ex_wreg = 1'b1; ex_wdata = wdata;
        ex_pc = pc; ex_mem_addr = addr; ex_store_data = sdata;
    endtask

    task automatic push_exp(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                            input logic [31:0] pc, input logic [7:0] op, input logic exc);
        res_t e;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.pc = pc; e.aluop = op; e.exc = exc;
        exp_q.push_back(e);
    endtask

    // Drives one aligned memory op to completion and reports what the bus side showed.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] pc, input int waits, input logic [31:0] rdata,
                           output int stall_cnt, output logic [3:0] sel, output logic [31:0] baddr,
                           output logic [31:0] bwdata, output logic bwe, output logic req_seen,
                           output logic stable, output int busy_valid, output logic req_after);
        logic is_st;
        is_st = (op == SB || op == SH || op == SW);
        @(negedge clk);
        drive_ex(op, 5'd7, 32'h5555_0000, pc, addr, sdata);
        push_exp(5'd7, ~is_st, is_st ? 32'h0 : exp_load(op, addr[1:0], rdata), pc, op, 1'b0);
        #1 stall_cnt = int'(stall_req);
        @(negedge clk);
        req_seen = dbus_req; sel = dbus_sel; baddr = dbus_addr; bwdata = dbus_wdata; bwe = dbus_we;
        stable = 1'b1;
        busy_valid = int'(mem_valid);
        drive_ex(ADD, 5'd31, 32'hBAD0_BAD0, 32'hFFFF_0000, 32'h0, 32'h0);
        for (int i = 0; i < waits; i++) begin
            dbus_ack = 1'b0;
            dbus_rdata = 32'hA5A5_A5A5;
            #1 stall_cnt += int'(stall_req);
            @(negedge clk);
            busy_valid += int'(mem_valid);
            if ({dbus_req, dbus_sel, dbus_addr, dbus_wdata, dbus_we} !== {req_seen, sel, baddr, bwdata, bwe})
                stable = 1'b0;
        end
        ex_valid = 1'b0;
        dbus_ack = 1'b1;
        dbus_rdata = rdata;
        #1 stall_cnt += int'(stall_req);
        @(negedge clk);
        dbus_ack = 1'b0;
        req_after = dbus_req;
    endtask

    task automatic test_reset;
        rst = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
        drive_ex(LW, 5'd1, 32'h1, 32'h4, 32'h8, 32'h0);
        #12;
        n_total++;
        if ({mem_valid, mem_wd, mem_wreg, mem_wdata, mem_pc, mem_aluop, misalign_exc,
             dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata} !== '0)
            $display("FAIL reset_outputs got valid=%b wdata=%h req=%b sel=%b required all zero",
                     mem_valid, mem_wdata, dbus_req, dbus_sel);
        else n_pass++;
        n_total++;
        if (stall_req !== 1'b0) $display("FAIL reset_stall got %b required 0", stall_req);
        else n_pass++;
        ex_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_nonmem;
        @(negedge clk);
        drive_ex(ADD, 5'd3, 32'h1234, 32'h100, 32'h0, 32'h0);
        push_exp(5'd3, 1'b1, 32'h1234, 32'h100, ADD, 1'b0);
        #1 n_total++;
        if (stall_req !== 1'b0) $display("FAIL nonmem_stall got %b required 0", stall_req);
        else n_pass++;
        @(negedge clk);
        ex_valid = 1'b0;
        n_total++;
        if (mem_valid !== 1'b1 || mem_wd !== 5'd3 || mem_wdata !== 32'h1234)
            $display("FAIL nonmem_latency got valid=%b wd=%0d wdata=%h required 1 3 00001234",
                     mem_valid, mem_wd, mem_wdata);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (mem_valid !== 1'b0 || mem_wd !== 5'd3 || mem_wdata !== 32'h1234)
            $display("FAIL idle_hold got valid=%b wd=%0d wdata=%h required 0 3 00001234",
                     mem_valid, mem_wd, mem_wdata);
        else n_pass++;
    endtask

    task automatic test_load_byte;
        int st, bv; logic [3:0] sel; logic [31:0] a, wd; logic we, rq, stb, ra;
        run_mem(LB, 32'h1001, 32'h0, 32'h200, 3, 32'h0080_0000, st, sel, a, wd, we, rq, stb, bv, ra);
        n_total++;
        if (rq !== 1'b1 || sel !== 4'b0100 || a !== 32'h1000 || we !== 1'b0)
            $display("FAIL lb_bus got req=%b sel=%b addr=%h we=%b required 1 0100 00001000 0", rq, sel, a, we);
        else n_pass++;
        n_total++;
        if (st !== 4) $display("FAIL lb_stall_cycles got %0d required 4", st);
        else n_pass++;
        n_total++;
        if (stb !== 1'b1 || bv !== 0 || ra !== 1'b0)
            $display("FAIL lb_busy got stable=%b busy_valid=%0d req_after=%b required 1 0 0", stb, bv, ra);
        else n_pass++;
        n_total++;
        if (mem_valid !== 1'b1 || mem_wdata !== 32'hFFFF_FF80)
            $display("FAIL lb_data got valid=%b wdata=%h required 1 ffffff80", mem_valid, mem_wdata);
        else n_pass++;
    endtask

    task automatic test_store_half;
        int st, bv; logic [3:0] sel; logic [31:0] a, wd; logic we, rq, stb, ra;
        run_mem(SH, 32'h2002, 32'hABCD, 32'h300, 1, 32'h0, st, sel, a, wd, we, rq, stb, bv, ra);
        n_total++;
        if (we !== 1'b1 || sel !== 4'b0011 || wd !== 32'hABCD_ABCD || a !== 32'h2000)
            $display("FAIL sh_bus got we=%b sel=%b wdata=%h addr=%h required 1 0011 abcdabcd 00002000",
                     we, sel, wd, a);
        else n_pass++;
        n_total++;
        if (mem_wreg !== 1'b0 || mem_wdata !== 32'h0)
            $display("FAIL sh_result got wreg=%b wdata=%h required 0 00000000", mem_wreg, mem_wdata);
        else n_pass++;
    endtask

    task automatic test_misaligned;
        @(negedge clk);
        drive_ex(LW, 5'd9, 32'h0, 32'h400, 32'h3001, 32'h0);
        push_exp(5'd9, 1'b0, 32'h3001, 32'h400, LW, 1'b1);
        #1 n_total++;
        if (stall_req !== 1'b0) $display("FAIL misalign_stall got %b required 0", stall_req);
        else n_pass++;
        @(negedge clk);
        ex_valid = 1'b0;
        n_total++;
        if (dbus_req !== 1'b0 || misalign_exc !== 1'b1 || mem_valid !== 1'b1 || mem_wdata !== 32'h3001)
            $display("FAIL misalign got req=%b exc=%b valid=%b wdata=%h required 0 1 1 00003001",
                     dbus_req, misalign_exc, mem_valid, mem_wdata);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (misalign_exc !== 1'b0 || dbus_req !== 1'b0)
            $display("FAIL misalign_pulse got exc=%b req=%b required 0 0", misalign_exc, dbus_req);
        else n_pass++;
    endtask

    task automatic test_lhu_fast;
        int st, bv; logic [3:0] sel; logic [31:0] a, wd; logic we, rq, stb, ra;
        run_mem(LHU, 32'h0, 32'h0, 32'h500, 0, 32'h8001_0000, st, sel, a, wd, we, rq, stb, bv, ra);
        n_total++;
        if (st !== 1 || sel !== 4'b1100 || bv !== 0)
            $display("FAIL lhu_fast got stall=%0d sel=%b busy_valid=%0d required 1 1100 0", st, sel, bv);
        else n_pass++;
        n_total++;
        if (mem_valid !== 1'b1 || mem_wdata !== 32'h0000_8001 || mem_wreg !== 1'b1)
            $display("FAIL lhu_data got valid=%b wdata=%h wreg=%b required 1 00008001 1",
                     mem_valid, mem_wdata, mem_wreg);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0]  ops[7]   = '{SW, LB, LB, LH, LBU, SB, LW};
        logic [31:0] addrs[7] = '{32'h40, 32'h50, 32'h52, 32'h62, 32'h73, 32'h86, 32'h90};
        int st, bv; logic [3:0] sel; logic [31:0] a, wd, rd, sd; logic we, rq, stb, ra;
        @(negedge clk);
        drive_ex(ADD, 5'd4, 32'hAAAA, 32'h600, 32'h0, 32'h0);
        push_exp(5'd4, 1'b1, 32'hAAAA, 32'h600, ADD, 1'b0);
        @(negedge clk);
        drive_ex(ADD, 5'd5, 32'hBBBB, 32'h604, 32'h0, 32'h0);
        push_exp(5'd5, 1'b1, 32'hBBBB, 32'h604, ADD, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rd = $urandom();
            sd = $urandom();
            run_mem(ops[i], addrs[i], sd, 32'h700 + 32'(i * 4), i % 3, rd, st, sel, a, wd, we, rq, stb, bv, ra);
            n_total++;
            if (sel !== exp_sel(ops[i], addrs[i][1:0]) || a !== {addrs[i][31:2], 2'b00} ||
                we !== (ops[i] == SB || ops[i] == SW) || stb !== 1'b1 || st !== 1 + i % 3 ||
                (we && wd !== exp_sdata(ops[i], sd)))
                $display("FAIL b2b_bus op=%h got sel=%b addr=%h we=%b wdata=%h stall=%0d stable=%b required sel=%b addr=%h wdata=%h stall=%0d",
                         ops[i], sel, a, we, wd, st, stb, exp_sel(ops[i], addrs[i][1:0]),
                         {addrs[i][31:2], 2'b00}, exp_sdata(ops[i], sd), 1 + i % 3);
            else n_pass++;
        end
    endtask

    task automatic test_ack_idle;
        @(negedge clk);
        ex_valid = 1'b0;
        dbus_ack = 1'b1;
        dbus_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        n_total++;
        if (mem_valid !== 1'b0 || dbus_req !== 1'b0 || stall_req !== 1'b0)
            $display("FAIL ack_in_idle got valid=%b req=%b stall=%b required 0 0 0", mem_valid, dbus_req, stall_req);
        else n_pass++;
        dbus_ack = 1'b0;
    endtask

    task automatic test_reset_busy;
        @(negedge clk);
        drive_ex(LW, 5'd2, 32'h0, 32'h800, 32'h10, 32'h0);
        @(negedge clk);
        ex_valid = 1'b0;
        n_total++;
        if (dbus_req !== 1'b1) $display("FAIL rst_busy_pre got req=%b required 1", dbus_req);
        else n_pass++;
        #2 rst = 1'b0;
        #1 n_total++;
        if (dbus_req !== 1'b0 || stall_req !== 1'b0 || mem_valid !== 1'b0)
            $display("FAIL rst_busy_abort got req=%b stall=%b valid=%b required 0 0 0", dbus_req, stall_req, mem_valid);
        else n_pass++;
        @(negedge clk);
        dbus_ack = 1'b1;
        dbus_rdata = 32'h1111_2222;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        dbus_ack = 1'b0;
        n_total++;
        if (mem_valid !== 1'b0 || dbus_req !== 1'b0 || stall_req !== 1'b0)
            $display("FAIL rst_busy_late_ack got valid=%b req=%b stall=%b required 0 0 0", mem_valid, dbus_req, stall_req);
        else n_pass++;
        drive_ex(ADD, 5'd6, 32'h6666, 32'h900, 32'h0, 32'h0);
        push_exp(5'd6, 1'b1, 32'h6666, 32'h900, ADD, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        n_total++;
        if (mem_valid !== 1'b1 || mem_wdata !== 32'h6666)
            $display("FAIL rst_busy_idle got valid=%b wdata=%h required 1 00006666", mem_valid, mem_wdata);
        else n_pass++;
    endtask

    task automatic test_drain;
        repeat (3) @(negedge clk);
        n_total++;
        if (exp_q.size() != 0) $display("FAIL drain got %0d pending required 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_lhu_fast();
        test_back_to_back();
        test_ack_idle();
        test_reset_busy();
        test_drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have ports, in order: name, direction, width, meaning.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ex_valid  in  1  EX/MEM holds a valid instruction.
REQ-005 ex_wd, ex_wreg, ex_wdata, ex_pc, ex_aluop  in  5/1/32/32/8  destination register, write-enable, ALU result, PC, ALU opcode.
REQ-006 ex_mem_addr, ex_store_data  in  32/32  effective address, store operand.
REQ-007 stall_req  out  1  combinational; upstream holds all ex_* while high.
REQ-008 mem_valid, mem_wd, mem_wreg, mem_wdata, mem_pc, mem_aluop  out  1/5/1/32/32/8  registered result to MEM/WB.
REQ-009 misalign_exc  out  1  registered one-cycle pulse, aligned with mem_valid.
REQ-010 dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata  out  1/1/4/32/32  registered data-bus request.
REQ-011 dbus_ack, dbus_rdata  in  1/32  bus completion, read data valid when dbus_ack=1.

Function
REQ-012 Memory opcodes SHALL be: LB=8'h20, LH=8'h21, LW=8'h23, LBU=8'h24, LHU=8'h25, SB=8'h28, SH=8'h29, SW=8'h2B; all others non-memory.
REQ-013 FSM SHALL have exactly two states, IDLE and BUSY.
REQ-014 ex_* SHALL be sampled only in IDLE with ex_valid=1; in BUSY, ex_* are ignored.
REQ-015 IDLE, non-memory op: next edge mem_valid=1, mem_* = ex_* copies; latency 1 cycle; stall_req=0.
REQ-016 IDLE, ex_valid=0: next edge mem_valid=0; other mem_* hold.
REQ-017 Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; byte ops always aligned.
REQ-018 IDLE, misaligned memory op: no bus request; next edge mem_valid=1, misalign_exc=1, mem_wreg=0, mem_wdata=ex_mem_addr; stall_req=0.
REQ-019 IDLE, aligned memory op: stall_req=1 that cycle; next edge state=BUSY, dbus_req=1, all bus fields and ex_* latched.
REQ-020 dbus_addr SHALL be {addr[31:2],2'b00}; dbus_we=1 for stores only.
REQ-021 Byte lanes are big-endian: byte offset 0 maps to bits [31:24], sel 4'b1000; halfword offset 0 maps to [31:16], sel 4'b1100; word sel 4'b1111.
REQ-022 Store data SHALL be replicated: SB {4{data[7:0]}}, SH {2{data[15:0]}}, SW data.
REQ-023 BUSY: dbus_req and all dbus_* SHALL stay constant until dbus_ack=1.
REQ-024 BUSY: stall_req = ~dbus_ack.
REQ-025 On the edge where BUSY and dbus_ack=1: state=IDLE, dbus_req=0, mem_valid=1.
REQ-026 On that ack edge, loads SHALL produce mem_wdata as the selected lane (sign-extended for LB/LH, zero-extended for LBU/LHU) and mem_wreg=ex_wreg.
REQ-027 On that ack edge, stores SHALL produce mem_wreg=0 and mem_wdata=0.
REQ-028 In BUSY, mem_valid=0 every cycle before the ack edge.
REQ-029 Minimum memory-op occupancy SHALL be 2 cycles (ack in the first request cycle); there is no upper bound.
REQ-030 dbus_ack while in IDLE SHALL be ignored.
REQ-031 misalign_exc SHALL be 0 except on the cycle defined in REQ-018.

Reset
REQ-032 While rst=0, asynchronously: state=IDLE, mem_valid=0, mem_wd=0, mem_wreg=0, mem_wdata=0, mem_pc=0, mem_aluop=0, misalign_exc=0, dbus_req=0, dbus_we=0, dbus_sel=0, dbus_addr=0, dbus_wdata=0.
REQ-033 While rst=0, stall_req SHALL be 0.
REQ-034 Reset during BUSY SHALL abort the transaction; a later dbus_ack SHALL be ignored.

Verification
REQ-035 Non-memory op: ADD, wd=3, wdata=32'h1234 -> next cycle mem_valid=1, mem_wd=3, mem_wdata=32'h1234, stall_req never asserted.
REQ-036 LB addr=32'h1001, dbus_rdata=32'h0080_0000 with ack after 3 wait cycles -> dbus_sel=4'b0100, dbus_addr=32'h1000, stall_req high 4 cycles, mem_wdata=32'hFFFF_FF80.
REQ-037 SH addr=32'h2002, data=32'hABCD -> dbus_we=1, sel=4'b0011, dbus_wdata=32'hABCD_ABCD, mem_wreg=0.
REQ-038 LW addr=32'h3001 -> no dbus_req, misalign_exc=1 with mem_valid=1, mem_wdata=32'h3001, mem_wreg=0.
REQ-039 LHU addr=0 with ack in first BUSY cycle, rdata=32'h8001_0000 -> 2-cycle occupancy, mem_wdata=32'h0000_8001.
REQ-040 rst=0 asserted mid-BUSY, then dbus_ack -> dbus_req=0 immediately, mem_valid stays 0, state IDLE.
